// File: rtl/pcie_ltssm_pkg.sv
// ============================================================================
// Module  : pcie_ltssm_pkg
// Brief   : Shared types and helpers for the PCIe LTSSM controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_ltssm_pkg;

    typedef enum logic [3:0] {
        DETECT   = 4'd0,
        POLLING  = 4'd1,
        CONFIG   = 4'd2,
        RECOVERY = 4'd3,
        L0       = 4'd4,
        L0S      = 4'd5,
        L1       = 4'd6,
        L2       = 4'd7,
        DISABLED = 4'd8,
        LOOPBACK = 4'd9,
        HOTRESET = 4'd10
    } ltssm_state_t;

    localparam int MAX_LANES = 16;
    localparam int WIDTH_W   = 5;
    localparam int RETRY_W   = 2;
    localparam int STAT_W    = 16;

    // Largest legal link width not exceeding the number of detected lanes.
    function automatic logic [WIDTH_W-1:0] width_from_mask(input logic [MAX_LANES-1:0] mask);
        logic [WIDTH_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            cnt = cnt + WIDTH_W'(mask[i]);
        end
        if (cnt >= 5'd16)     return 5'd16;
        else if (cnt >= 5'd8) return 5'd8;
        else if (cnt >= 5'd4) return 5'd4;
        else if (cnt >= 5'd2) return 5'd2;
        else                  return 5'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pcie_ltssm_timer.sv
// ============================================================================
// Module  : pcie_ltssm_timer
// Brief   : Saturating per-state timer with clear and limit compare.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_ltssm_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [TIMER_W-1:0] limit,
    output logic               timeout
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + TIMER_W'(1);
        end
    end

    // Fires during the limit-th cycle so the exit edge lands after exactly limit cycles.
    assign timeout = (r_count == (limit - TIMER_W'(1)));

endmodule

`default_nettype wire

// File: rtl/pcie_ltssm_ctrl.sv
// ============================================================================
// Module  : pcie_ltssm_ctrl
// Brief   : PCIe LTSSM controller with state timeouts, recovery retry and
//           lane-width negotiation. Optional statistics: PCIE_LTSSM_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_ltssm_ctrl
    import pcie_ltssm_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int TIMER_W       = 16,
    parameter int POLL_TIMEOUT  = 24000,
    parameter int CFG_TIMEOUT   = 24000,
    parameter int REC_TIMEOUT   = 12000,
    parameter int MAX_REC_RETRY = 3,
    parameter int HOLD_CYCLES   = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 init_state,
    input  logic [NUM_LANES-1:0] rx_detected,
    input  logic                 ts_rx_ok,
    input  logic                 cfg_done,
    input  logic                 rec_done,
    input  logic                 rec_to_cfg,
    input  logic                 dir_retrain,
    input  logic                 dir_disable,
    input  logic                 dir_hotreset,
    input  logic                 dir_loopback,
    input  logic                 loopback_exit,
    input  logic                 req_l0s,
    input  logic                 req_l1,
    input  logic                 req_l2,
    input  logic                 idle_exit,
    output logic                 link_up,
    output logic [3:0]           ltssm_state,
    output logic [NUM_LANES-1:0] lane_mask,
    output logic [4:0]           link_width,
    output logic                 timeout_err,
    output logic [1:0]           rec_retry,
    output logic [15:0]          stat_rec_cnt,
    output logic [15:0]          stat_down_cnt
);

    localparam logic [RETRY_W-1:0] c_retry_last = RETRY_W'(MAX_REC_RETRY - 1);

    ltssm_state_t           r_state;
    ltssm_state_t           w_next_state;
    logic                   w_timeout;
    logic                   w_timeout_err;
    logic                   w_retry_inc;
    logic                   w_timer_clear;
    logic [TIMER_W-1:0]     w_limit;
    logic                   w_link_up;
    logic                   w_enter_detect;
    logic                   w_enter_l0;
    logic                   w_latch_mask;
    logic                   w_set_width;
    logic                   r_timeout_err;
    logic [RETRY_W-1:0]     r_rec_retry;
    logic [NUM_LANES-1:0]   r_lane_mask;
    logic [WIDTH_W-1:0]     r_link_width;

    always_comb begin
        case (r_state)
            POLLING:            w_limit = TIMER_W'(POLL_TIMEOUT);
            CONFIG:             w_limit = TIMER_W'(CFG_TIMEOUT);
            RECOVERY:           w_limit = TIMER_W'(REC_TIMEOUT);
            DISABLED, HOTRESET: w_limit = TIMER_W'(HOLD_CYCLES);
            default:            w_limit = '1;
        endcase
    end

    // A recovery retry restarts the timer without leaving the state.
    assign w_timer_clear = (w_next_state != r_state) || w_retry_inc;

    pcie_ltssm_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_timer_clear),
        .limit   (w_limit),
        .timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DETECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_timeout_err = 1'b0;
        w_retry_inc   = 1'b0;
        if (init_state) begin
            w_next_state = DETECT;
        end else begin
            case (r_state)
                DETECT: begin
                    if (|rx_detected) w_next_state = POLLING;
                end
                POLLING: begin
                    if (w_timeout) begin
                        w_next_state  = DETECT;
                        w_timeout_err = 1'b1;
                    end else if (ts_rx_ok) begin
                        w_next_state = CONFIG;
                    end
                end
                CONFIG: begin
                    if (w_timeout) begin
                        w_next_state  = DETECT;
                        w_timeout_err = 1'b1;
                    end else if (dir_disable)  w_next_state = DISABLED;
                    else if (dir_loopback)     w_next_state = LOOPBACK;
                    else if (cfg_done)         w_next_state = L0;
                end
                L0: begin
                    if (dir_retrain)  w_next_state = RECOVERY;
                    else if (req_l2)  w_next_state = L2;
                    else if (req_l1)  w_next_state = L1;
                    else if (req_l0s) w_next_state = L0S;
                end
                L0S: if (idle_exit) w_next_state = L0;
                L1:  if (idle_exit) w_next_state = RECOVERY;
                L2:  if (idle_exit) w_next_state = DETECT;
                RECOVERY: begin
                    if (dir_disable)       w_next_state = DISABLED;
                    else if (dir_hotreset) w_next_state = HOTRESET;
                    else if (dir_loopback) w_next_state = LOOPBACK;
                    else if (rec_done)     w_next_state = L0;
                    else if (rec_to_cfg)   w_next_state = CONFIG;
                    else if (w_timeout) begin
                        if (r_rec_retry == c_retry_last) begin
                            w_next_state  = DETECT;
                            w_timeout_err = 1'b1;
                        end else begin
                            w_retry_inc = 1'b1;
                        end
                    end
                end
                DISABLED, HOTRESET: if (w_timeout) w_next_state = DETECT;
                LOOPBACK: if (loopback_exit) w_next_state = DETECT;
                default:  w_next_state = DETECT;
            endcase
        end
    end

    always_comb begin
        w_link_up      = (r_state == L0) || (r_state == L0S) || (r_state == L1);
        w_enter_detect = (w_next_state == DETECT) && ((r_state != DETECT) || init_state);
        w_enter_l0     = (w_next_state == L0) && (r_state != L0);
        w_latch_mask   = (r_state == DETECT) && (w_next_state == POLLING);
        w_set_width    = (r_state == CONFIG) && (w_next_state == L0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timeout_err <= 1'b0;
            r_rec_retry   <= '0;
            r_lane_mask   <= '0;
            r_link_width  <= '0;
        end else begin
            r_timeout_err <= w_timeout_err;
            if (init_state || w_enter_l0) begin
                r_rec_retry <= '0;
            end else if (w_retry_inc) begin
                r_rec_retry <= r_rec_retry + RETRY_W'(1);
            end
            if (w_enter_detect) begin
                r_lane_mask  <= '0;
                r_link_width <= '0;
            end else begin
                if (w_latch_mask) r_lane_mask  <= rx_detected;
                if (w_set_width)  r_link_width <= width_from_mask(MAX_LANES'(r_lane_mask));
            end
        end
    end

`ifdef PCIE_LTSSM_STATS_EN
    logic              w_link_down;
    logic              w_rec_entry;
    logic [STAT_W-1:0] r_stat_rec;
    logic [STAT_W-1:0] r_stat_down;

    assign w_link_down = w_link_up &&
                         ((w_next_state == DETECT)   || (w_next_state == DISABLED) ||
                          (w_next_state == HOTRESET) || (w_next_state == LOOPBACK));
    assign w_rec_entry = (w_next_state == RECOVERY) && (r_state != RECOVERY);

    // Only reset_n clears the statistics; init_state leaves them intact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_rec  <= '0;
            r_stat_down <= '0;
        end else begin
            if (w_rec_entry && (r_stat_rec != '1))  r_stat_rec  <= r_stat_rec + STAT_W'(1);
            if (w_link_down && (r_stat_down != '1)) r_stat_down <= r_stat_down + STAT_W'(1);
        end
    end

    assign stat_rec_cnt  = r_stat_rec;
    assign stat_down_cnt = r_stat_down;
`else
    assign stat_rec_cnt  = '0;
    assign stat_down_cnt = '0;
`endif

    assign link_up     = w_link_up;
    assign ltssm_state = r_state;
    assign lane_mask   = r_lane_mask;
    assign link_width  = r_link_width;
    assign timeout_err = r_timeout_err;
    assign rec_retry   = r_rec_retry;

endmodule

`default_nettype wire

// File: tb/tb_pcie_ltssm_ctrl.sv
// ============================================================================
// Module  : tb_pcie_ltssm_ctrl
// Brief   : Directed, table-driven bench for pcie_ltssm_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcie_ltssm_ctrl;
    import pcie_ltssm_pkg::*;

    localparam logic [12:0] EV_NONE = 13'h0000;
    localparam logic [12:0] EV_TS   = 13'h0001;
    localparam logic [12:0] EV_CFG  = 13'h0002;
    localparam logic [12:0] EV_RECD = 13'h0004;
    localparam logic [12:0] EV_R2C  = 13'h0008;
    localparam logic [12:0] EV_RETR = 13'h0010;
    localparam logic [12:0] EV_DIS  = 13'h0020;
    localparam logic [12:0] EV_HOT  = 13'h0040;
    localparam logic [12:0] EV_LB   = 13'h0080;
    localparam logic [12:0] EV_LBX  = 13'h0100;
    localparam logic [12:0] EV_L0S  = 13'h0200;
    localparam logic [12:0] EV_L1   = 13'h0400;
    localparam logic [12:0] EV_L2   = 13'h0800;
    localparam logic [12:0] EV_IDLE = 13'h1000;

    typedef struct {
        logic        init;
        logic [3:0]  rx;
        logic [12:0] ev;
        logic [3:0]  exp_state;
        logic        exp_up;
        logic [3:0]  exp_mask;
        logic [4:0]  exp_width;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       init_state = 1'b0;
    logic [3:0] rx_detected = '0;
    logic ts_rx_ok = 0, cfg_done = 0, rec_done = 0, rec_to_cfg = 0, dir_retrain = 0;
    logic dir_disable = 0, dir_hotreset = 0, dir_loopback = 0, loopback_exit = 0;
    logic req_l0s = 0, req_l1 = 0, req_l2 = 0, idle_exit = 0;
    logic        link_up;
    logic [3:0]  ltssm_state;
    logic [3:0]  lane_mask;
    logic [4:0]  link_width;
    logic        timeout_err;
    logic [1:0]  rec_retry;
    logic [15:0] stat_rec_cnt;
    logic [15:0] stat_down_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[24];

    pcie_ltssm_ctrl #(
        .NUM_LANES(4), .TIMER_W(16), .POLL_TIMEOUT(100), .CFG_TIMEOUT(200),
        .REC_TIMEOUT(50), .MAX_REC_RETRY(3), .HOLD_CYCLES(256)
    ) dut (
        .clk(clk), .reset_n(reset_n), .init_state(init_state), .rx_detected(rx_detected),
        .ts_rx_ok(ts_rx_ok), .cfg_done(cfg_done), .rec_done(rec_done), .rec_to_cfg(rec_to_cfg),
        .dir_retrain(dir_retrain), .dir_disable(dir_disable), .dir_hotreset(dir_hotreset),
        .dir_loopback(dir_loopback), .loopback_exit(loopback_exit), .req_l0s(req_l0s),
        .req_l1(req_l1), .req_l2(req_l2), .idle_exit(idle_exit), .link_up(link_up),
        .ltssm_state(ltssm_state), .lane_mask(lane_mask), .link_width(link_width),
        .timeout_err(timeout_err), .rec_retry(rec_retry), .stat_rec_cnt(stat_rec_cnt),
        .stat_down_cnt(stat_down_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic vec_t mk(logic init, logic [3:0] rx, logic [12:0] ev, logic [3:0] st,
                                logic up, logic [3:0] mask, logic [4:0] w);
        vec_t v;
        v.init = init; v.rx = rx; v.ev = ev;
        v.exp_state = st; v.exp_up = up; v.exp_mask = mask; v.exp_width = w;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic init, input logic [3:0] rx, input logic [12:0] ev);
        init_state    = init;
        rx_detected   = rx;
        ts_rx_ok      = ev[0];
        cfg_done      = ev[1];
        rec_done      = ev[2];
        rec_to_cfg    = ev[3];
        dir_retrain   = ev[4];
        dir_disable   = ev[5];
        dir_hotreset  = ev[6];
        dir_loopback  = ev[7];
        loopback_exit = ev[8];
        req_l0s       = ev[9];
        req_l1        = ev[10];
        req_l2        = ev[11];
        idle_exit     = ev[12];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train_to_l0(input logic [3:0] rx);
        apply(1'b0, rx, EV_NONE);   tick();
        apply(1'b0, 4'h0, EV_TS);   tick();
        apply(1'b0, 4'h0, EV_CFG);  tick();
        apply(1'b0, 4'h0, EV_NONE);
    endtask

    initial begin
        int  n;
        logic seen_bad;

        vecs[0]  = mk(0, 4'h0, EV_TS | EV_CFG, DETECT,   0, 4'h0, 5'd0);
        vecs[1]  = mk(0, 4'hB, EV_NONE,        POLLING,  0, 4'hB, 5'd0);
        vecs[2]  = mk(0, 4'h0, EV_TS,          CONFIG,   0, 4'hB, 5'd0);
        vecs[3]  = mk(0, 4'h0, EV_CFG,         L0,       1, 4'hB, 5'd2);
        vecs[4]  = mk(0, 4'h0, EV_NONE,        L0,       1, 4'hB, 5'd2);
        vecs[5]  = mk(0, 4'h0, EV_L1,          L1,       1, 4'hB, 5'd2);
        vecs[6]  = mk(0, 4'h0, EV_NONE,        L1,       1, 4'hB, 5'd2);
        vecs[7]  = mk(0, 4'h0, EV_IDLE,        RECOVERY, 0, 4'hB, 5'd2);
        vecs[8]  = mk(0, 4'h0, EV_RECD,        L0,       1, 4'hB, 5'd2);
        vecs[9]  = mk(0, 4'h0, EV_L0S,         L0S,      1, 4'hB, 5'd2);
        vecs[10] = mk(0, 4'h0, EV_IDLE,        L0,       1, 4'hB, 5'd2);
        vecs[11] = mk(0, 4'h0, EV_RETR,        RECOVERY, 0, 4'hB, 5'd2);
        vecs[12] = mk(0, 4'h0, EV_R2C,         CONFIG,   0, 4'hB, 5'd2);
        vecs[13] = mk(0, 4'h0, EV_LB | EV_CFG, LOOPBACK, 0, 4'hB, 5'd2);
        vecs[14] = mk(0, 4'h0, EV_LBX,         DETECT,   0, 4'h0, 5'd0);
        vecs[15] = mk(0, 4'hF, EV_NONE,        POLLING,  0, 4'hF, 5'd0);
        vecs[16] = mk(0, 4'h0, EV_TS,          CONFIG,   0, 4'hF, 5'd0);
        vecs[17] = mk(0, 4'h0, EV_CFG,         L0,       1, 4'hF, 5'd4);
        vecs[18] = mk(0, 4'h0, EV_L2 | EV_L1,  L2,       0, 4'hF, 5'd4);
        vecs[19] = mk(0, 4'h0, EV_IDLE,        DETECT,   0, 4'h0, 5'd0);
        vecs[20] = mk(0, 4'h1, EV_NONE,        POLLING,  0, 4'h1, 5'd0);
        vecs[21] = mk(0, 4'h0, EV_TS,          CONFIG,   0, 4'h1, 5'd0);
        vecs[22] = mk(0, 4'h0, EV_CFG,         L0,       1, 4'h1, 5'd1);
        vecs[23] = mk(1, 4'h0, EV_RETR,        DETECT,   0, 4'h0, 5'd0);

        // Reset state
        apply(1'b0, 4'h0, EV_NONE);
        tick(); tick();
        check("reset_state", 32'(ltssm_state), 32'(DETECT));
        check("reset_outs", {link_up, lane_mask, link_width, timeout_err, rec_retry}, 32'h0);
        reset_n = 1'b1;

        // Single-cycle transition table
        for (int i = 0; i < 24; i++) begin
            apply(vecs[i].init, vecs[i].rx, vecs[i].ev);
            tick();
            check($sformatf("vec%0d_state", i), 32'(ltssm_state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_up", i),    32'(link_up),     32'(vecs[i].exp_up));
            check($sformatf("vec%0d_mask", i),  32'(lane_mask),   32'(vecs[i].exp_mask));
            check($sformatf("vec%0d_width", i), 32'(link_width),  32'(vecs[i].exp_width));
        end

        // POLLING timeout after 100 cycles
        apply(1'b0, 4'h1, EV_NONE); tick();
        apply(1'b0, 4'h0, EV_NONE);
        n = 0; seen_bad = 1'b0;
        while (ltssm_state == 4'(POLLING) && n < 300) begin
            if (link_up || timeout_err) seen_bad = 1'b1;
            tick(); n++;
        end
        check("poll_to_cycles", 32'(n), 32'd100);
        check("poll_to_state", 32'(ltssm_state), 32'(DETECT));
        check("poll_to_err", 32'(timeout_err), 32'd1);
        check("poll_to_quiet", 32'(seen_bad), 32'd0);
        tick();
        check("poll_to_err_pulse", 32'(timeout_err), 32'd0);

        // Recovery retries exhaust after 3 x 50 cycles
        train_to_l0(4'h3);
        check("rec_l0_width", 32'(link_width), 32'd2);
        apply(1'b0, 4'h0, EV_RETR); tick();
        apply(1'b0, 4'h0, EV_NONE);
        n = 0; seen_bad = 1'b0;
        while (ltssm_state == 4'(RECOVERY) && n < 400) begin
            if (32'(rec_retry) != 32'(n / 50) || timeout_err) seen_bad = 1'b1;
            tick(); n++;
        end
        check("rec_to_cycles", 32'(n), 32'd150);
        check("rec_to_retry_seq", 32'(seen_bad), 32'd0);
        check("rec_to_state", 32'(ltssm_state), 32'(DETECT));
        check("rec_to_err", 32'(timeout_err), 32'd1);

        // rec_done coinciding with a RECOVERY timeout wins
        train_to_l0(4'h3);
        apply(1'b0, 4'h0, EV_RETR); tick();
        apply(1'b0, 4'h0, EV_NONE);
        for (int k = 0; k < 49; k++) tick();
        check("rec_tie_pre_state", 32'(ltssm_state), 32'(RECOVERY));
        apply(1'b0, 4'h0, EV_RECD); tick();
        check("rec_tie_state", 32'(ltssm_state), 32'(L0));
        check("rec_tie_err", 32'(timeout_err), 32'd0);
        check("rec_tie_retry", 32'(rec_retry), 32'd0);

        // HOTRESET beats rec_done, directed inputs ignored during the 256-cycle dwell
        apply(1'b0, 4'h0, EV_RETR); tick();
        apply(1'b0, 4'h0, EV_HOT | EV_RECD); tick();
        check("hot_state", 32'(ltssm_state), 32'(HOTRESET));
        check("hot_link_up", 32'(link_up), 32'd0);
        apply(1'b0, 4'h0, EV_DIS | EV_LB | EV_RECD);
        n = 0;
        while (ltssm_state == 4'(HOTRESET) && n < 400) begin
            tick(); n++;
        end
        check("hot_cycles", 32'(n), 32'd256);
        check("hot_exit_state", 32'(ltssm_state), 32'(DETECT));
        check("hot_exit_err", 32'(timeout_err), 32'd0);

        // dir_disable outranks cfg_done in CONFIG
        apply(1'b0, 4'h1, EV_NONE); tick();
        apply(1'b0, 4'h0, EV_TS);   tick();
        apply(1'b0, 4'h0, EV_DIS | EV_CFG); tick();
        check("dis_state", 32'(ltssm_state), 32'(DISABLED));
        apply(1'b0, 4'h0, EV_NONE);
        n = 0;
        while (ltssm_state == 4'(DISABLED) && n < 400) begin
            tick(); n++;
        end
        check("dis_cycles", 32'(n), 32'd256);

`ifndef PCIE_LTSSM_STATS_EN
        check("stats_tied_off", {stat_rec_cnt, stat_down_cnt}, 32'h0);
`endif

        // Asynchronous reset in the middle of CONFIG
        apply(1'b0, 4'hB, EV_NONE); tick();
        apply(1'b0, 4'h0, EV_TS);   tick();
        apply(1'b0, 4'h0, EV_NONE);
        check("areset_pre_mask", 32'(lane_mask), 32'hB);
        #2 reset_n = 1'b0;
        #1;
        check("areset_state", 32'(ltssm_state), 32'(DETECT));
        check("areset_outs", {link_up, lane_mask, link_width, timeout_err, rec_retry}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check("areset_hold", 32'(ltssm_state), 32'(DETECT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
